// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Holds the FSM state encoding, requester identities and wait-counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_LDR  = 1'b1;

    // Largest preload is RD_LAT-2 = 2, so two bits cover the legal latency range.
    localparam int CNT_W = 2;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
// Purely combinational; the history bit is owned by the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = OWN_CORE;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = OWN_LDR;
        end
        if (|req) begin
            gnt = (winner == OWN_LDR) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port instruction/data memory between the core and the loader.
// One transaction in flight: grant, issue, then optional read wait and response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("mem_arbiter: RD_LAT must be within 1..4");
        end
    endgenerate

    // WAIT counts down from RD_LAT-2 so that RESP lands exactly RD_LAT cycles after ISSUE.
    localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic       arb_point;
    logic [1:0] elig;
    logic [1:0] pick;
    logic       winner;
    logic       grant;

    // Gating with rst_n keeps the combinational grants quiet while reset is held.
    assign arb_point = rst_n & ((state_q == ST_IDLE) |
                                (state_q == ST_RESP) |
                                ((state_q == ST_ISSUE) & we_q));

    assign elig = arb_point ? {ldr_req, core_req & ~ldr_lock} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req    (elig),
        .last   (last_q),
        .gnt    (pick),
        .winner (winner)
    );

    assign grant    = |pick;
    assign core_gnt = pick[0];
    assign ldr_gnt  = pick[1];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;

        if (grant) begin
            owner_d = winner;
            last_d  = winner;
            if (winner == OWN_LDR) begin
                we_d    = ldr_we;
                addr_d  = ldr_addr;
                wdata_d = ldr_wdata;
            end else begin
                we_d    = core_we;
                addr_d  = core_addr;
                wdata_d = core_wdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                state_d = grant ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = grant ? ST_ISSUE : ST_IDLE;
                end else if (RD_LAT == 1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = grant ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // History starts at the loader so the core takes the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_CORE;
            last_q  <= OWN_LDR;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        core_rvalid = 1'b0;
        core_rdata  = '0;
        ldr_rvalid  = 1'b0;
        ldr_rdata   = '0;

        if (state_q == ST_ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end

        if (state_q == ST_RESP) begin
            if (owner_q == OWN_LDR) begin
                ldr_rvalid = 1'b1;
                ldr_rdata  = mem_rdata;
            end else begin
                core_rvalid = 1'b1;
                core_rdata  = mem_rdata;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule
